io_gpio_irq: RTL

GPIO edge-capture and interrupt block on the IO bus, sitting directly upstream of the LED/GPIO output block in the read-data chain. Its `dma_io_rdata` output feeds that block's `dma_io_rdata_in`. It samples the four GPIO pins through its own synchronizer and optionally debounces them. It latches per-pin rising/falling edge events into a sticky status register and drives a single level interrupt line to the CPU.

---
 rtl/io_gpio_irq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/io_gpio_irq.sv
// GPIO edge-capture and interrupt block on the IO bus read-data chain.
// Define GPIO_IRQ_DEBOUNCE_EN to build the per-pin debounce counters and the DEBOUNCE register.
module io_gpio_irq (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic [3:0]  gpio_in,
  output logic        gpio_irq
);

  localparam logic [15:2] ADR_IRQ_EN   = 14'h3F88;
  localparam logic [15:2] ADR_IRQ_EDGE = 14'h3F89;
  localparam logic [15:2] ADR_IRQ_STAT = 14'h3F8A;
  localparam logic [15:2] ADR_DEBOUNCE = 14'h3F8B;

  // Bus write decode
  logic we_en, we_edge, we_stat, we_deb;

  always_comb begin
    we_en   = dma_io_we && (dma_io_wadr == ADR_IRQ_EN);
    we_edge = dma_io_we && (dma_io_wadr == ADR_IRQ_EDGE);
    we_stat = dma_io_we && (dma_io_wadr == ADR_IRQ_STAT);
    we_deb  = dma_io_we && (dma_io_wadr == ADR_DEBOUNCE);
  end

  // Configuration registers
  logic [3:0] irq_en_q,   irq_en_d;
  logic [7:0] irq_edge_q, irq_edge_d;
  logic [7:0] debounce_rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    if (we_en)   irq_en_d   = dma_io_wdata[3:0];
    if (we_edge) irq_edge_d = dma_io_wdata[7:0];
  end

  // Pin synchronizer and debounce
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] stable_q, stable_d;
  logic [3:0] stable_dly_q, stable_dly_d;

  always_comb begin
    sync1_d      = gpio_in;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [7:0]       debounce_q, debounce_d;
  logic [3:0][7:0]  cnt_q, cnt_d;

  always_comb begin
    debounce_d = debounce_q;
    if (we_deb) debounce_d = dma_io_wdata[7:0];
  end

  // A pin's stable level moves only after N+1 consecutive samples that disagree with it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] >= debounce_q) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      debounce_q <= 8'd0;
      cnt_q      <= '0;
    end else begin
      debounce_q <= debounce_d;
      cnt_q      <= cnt_d;
    end
  end

  assign debounce_rd = debounce_q;

  logic unused_wdata;
  assign unused_wdata = ^dma_io_wdata[31:8];
`else
  always_comb begin
    stable_d = sync2_q;
  end

  assign debounce_rd = 8'd0;

  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:8], we_deb};
`endif

  // Edge detect, sticky status and interrupt
  logic [3:0] rise, fall, set, clr;
  logic [3:0] stat_q, stat_d;
  logic       gpio_irq_q, gpio_irq_d;

  always_comb begin
    rise   = stable_q & ~stable_dly_q;
    fall   = ~stable_q & stable_dly_q;
    set    = (rise & irq_edge_q[3:0]) | (fall & irq_edge_q[7:4]);
    clr    = we_stat ? dma_io_wdata[3:0] : 4'd0;
    // Set is OR'd in after the clear so a new edge survives a coincident W1C.
    stat_d = (stat_q & ~clr) | set;
    gpio_irq_d = |(stat_q & irq_en_q);
  end

  assign gpio_irq = gpio_irq_q;

  // Read select pipeline
  logic re_en_dly_q,   re_en_dly_d;
  logic re_edge_dly_q, re_edge_dly_d;
  logic re_stat_dly_q, re_stat_dly_d;
  logic re_deb_dly_q,  re_deb_dly_d;

  always_comb begin
    re_en_dly_d   = dma_io_radr_en && (dma_io_radr == ADR_IRQ_EN);
    re_edge_dly_d = dma_io_radr_en && (dma_io_radr == ADR_IRQ_EDGE);
    re_stat_dly_d = dma_io_radr_en && (dma_io_radr == ADR_IRQ_STAT);
    re_deb_dly_d  = dma_io_radr_en && (dma_io_radr == ADR_DEBOUNCE);
  end

  always_comb begin
    dma_io_rdata = dma_io_rdata_in;
    if (re_en_dly_q)        dma_io_rdata = {28'd0, irq_en_q};
    else if (re_edge_dly_q) dma_io_rdata = {24'd0, irq_edge_q};
    else if (re_stat_dly_q) dma_io_rdata = {28'd0, stat_q};
    else if (re_deb_dly_q)  dma_io_rdata = {24'd0, debounce_rd};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q      <= 4'd0;
      irq_edge_q    <= 8'd0;
      sync1_q       <= 4'd0;
      sync2_q       <= 4'd0;
      stable_q      <= 4'd0;
      stable_dly_q  <= 4'd0;
      stat_q        <= 4'd0;
      gpio_irq_q    <= 1'b0;
      re_en_dly_q   <= 1'b0;
      re_edge_dly_q <= 1'b0;
      re_stat_dly_q <= 1'b0;
      re_deb_dly_q  <= 1'b0;
    end else begin
      irq_en_q      <= irq_en_d;
      irq_edge_q    <= irq_edge_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_dly_d;
      stat_q        <= stat_d;
      gpio_irq_q    <= gpio_irq_d;
      re_en_dly_q   <= re_en_dly_d;
      re_edge_dly_q <= re_edge_dly_d;
      re_stat_dly_q <= re_stat_dly_d;
      re_deb_dly_q  <= re_deb_dly_d;
    end
  end

endmodule
